// File: rtl/muldiv_iter_unit.sv
// Iterative multiply / multiply-accumulate / divide unit for the EX stage.
// One request in flight at a time; results land in hi/lo with a one-cycle out_valid pulse.
module muldiv_iter_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [1:0]       op_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic [WIDTH-1:0] in_hi_i,
    input  logic [WIDTH-1:0] in_lo_i,
    output logic             busy_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;
    localparam int N_ITER   = WIDTH / DIV_STEP;
    localparam int CNT_MAX  = (N_ITER > MUL_LAT) ? N_ITER : MUL_LAT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int MUL_LAST = (MUL_LAT >= 2) ? MUL_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] MUL_LAST_C  = CNT_W'(MUL_LAST);
    localparam logic [CNT_W-1:0] ITER_LAST_C = CNT_W'(N_ITER - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DPRE, S_DITER, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     opA_q, opA_d, opB_q, opB_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 divZero_q, divZero_d;

    logic                 accept;
    logic                 useLatched, mulSign;
    logic [1:0]           mulOp;
    logic [WIDTH-1:0]     mulA, mulB;
    logic [2*WIDTH-1:0]   mulAcc, extA, extB, prod, mulRes;
    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     remS, quotS, absA, absB, divHi, divLo;
    logic                 negQ, negR, divByZero;

    // A request is taken when idle, or in the result cycle so ops can issue back to back.
    assign accept = in_valid_i && !flush_i && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (!in_valid_i)           state_d = S_IDLE;
                    else if (op_i == OP_DIV)   state_d = S_DPRE;
                    else if (MUL_LAT == 1)     state_d = S_DONE;
                    else                       state_d = S_MUL;
                end
                S_MUL:   if (cnt_q == MUL_LAST_C)  state_d = S_DONE;
                S_DPRE:  state_d = S_DITER;
                S_DITER: if (cnt_q == ITER_LAST_C) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE) && !accept;
        out_valid_o = (state_q == S_DONE);
    end

    // With MUL_LAT == 1 the product is formed straight from the ports at the accept edge.
    always_comb begin
        useLatched = (state_q == S_MUL);
        mulA    = useLatched ? opA_q  : srca_i;
        mulB    = useLatched ? opB_q  : srcb_i;
        mulSign = useLatched ? sign_q : sign_i;
        mulOp   = useLatched ? op_q   : op_i;
        mulAcc  = useLatched ? acc_q  : {in_hi_i, in_lo_i};
        extA    = mulSign ? {{WIDTH{mulA[WIDTH-1]}}, mulA} : {{WIDTH{1'b0}}, mulA};
        extB    = mulSign ? {{WIDTH{mulB[WIDTH-1]}}, mulB} : {{WIDTH{1'b0}}, mulB};
        prod    = extA * extB;
        case (mulOp)
            OP_MADD: mulRes = mulAcc + prod;
            OP_MSUB: mulRes = mulAcc - prod;
            default: mulRes = prod;
        endcase
    end

    // Restoring divide on magnitudes; the sign fix-up is folded into the final iteration.
    always_comb begin
        remS    = rem_q;
        quotS   = quot_q;
        shifted = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            shifted = {remS, quotS[WIDTH-1]};
            quotS   = {quotS[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, dvsr_q}) begin
                shifted  = shifted - {1'b0, dvsr_q};
                quotS[0] = 1'b1;
            end
            remS = shifted[WIDTH-1:0];
        end
        absA      = (sign_q && opA_q[WIDTH-1]) ? -opA_q : opA_q;
        absB      = (sign_q && opB_q[WIDTH-1]) ? -opB_q : opB_q;
        negQ      = sign_q && (opA_q[WIDTH-1] ^ opB_q[WIDTH-1]);
        negR      = sign_q && opA_q[WIDTH-1];
        divByZero = (opB_q == '0);
        if (divByZero) begin
            divLo = '1;
            divHi = opA_q;
        end else begin
            divLo = negQ ? -quotS : quotS;
            divHi = negR ? -remS  : remS;
        end
    end

    always_comb begin
        cnt_d = cnt_q;  opA_d = opA_q;  opB_d = opB_q;  acc_d = acc_q;
        op_d = op_q;    sign_d = sign_q;
        quot_d = quot_q; rem_d = rem_q;  dvsr_d = dvsr_q;
        hi_d = hi_q;    lo_d = lo_q;     divZero_d = divZero_q;
        if (accept) begin
            opA_d  = srca_i;
            opB_d  = srcb_i;
            acc_d  = {in_hi_i, in_lo_i};
            op_d   = op_i;
            sign_d = sign_i;
            cnt_d  = '0;
            if (op_i != OP_DIV && MUL_LAT == 1) begin
                {hi_d, lo_d} = mulRes;
                divZero_d    = 1'b0;
            end
        end else if (!flush_i) begin
            case (state_q)
                S_MUL: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == MUL_LAST_C) begin
                        {hi_d, lo_d} = mulRes;
                        divZero_d    = 1'b0;
                    end
                end
                S_DPRE: begin
                    quot_d = absA;
                    dvsr_d = absB;
                    rem_d  = '0;
                    cnt_d  = '0;
                end
                S_DITER: begin
                    quot_d = quotS;
                    rem_d  = remS;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == ITER_LAST_C) begin
                        hi_d      = divHi;
                        lo_d      = divLo;
                        divZero_d = divByZero;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;  opA_q <= '0;  opB_q <= '0;  acc_q <= '0;
            op_q <= '0;   sign_q <= 1'b0;
            quot_q <= '0; rem_q <= '0;  dvsr_q <= '0;
            hi_q <= '0;   lo_q <= '0;   divZero_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;   opA_q <= opA_d;  opB_q <= opB_d;  acc_q <= acc_d;
            op_q <= op_d;     sign_q <= sign_d;
            quot_q <= quot_d; rem_q <= rem_d;  dvsr_q <= dvsr_d;
            hi_q <= hi_d;     lo_q <= lo_d;    divZero_q <= divZero_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = divZero_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: a reference model queues the expected result and the
// cycle it must appear in; a negedge monitor pops and compares whenever out_valid fires.
module tb_muldiv_iter_unit;

    localparam int W    = 32;
    localparam int LAT  = 2;
    localparam int STEP = 1;
    localparam int DLAT = W / STEP + 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, flush, inValid, sign;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb, inHi, inLo;
    logic         busy, outValid, divZero;
    logic [W-1:0] hi, lo;

    exp_t         expQ[$];
    exp_t         mon;
    int           checkCnt = 0;
    int           errCnt   = 0;
    int           edgeCnt  = 0;
    logic [W-1:0] lastHi = '0;
    logic [W-1:0] lastLo = '0;

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    muldiv_iter_unit #(.WIDTH(W), .MUL_LAT(LAT), .DIV_STEP(STEP)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(inValid),
        .op_i(op), .sign_i(sign), .srca_i(srca), .srcb_i(srcb),
        .in_hi_i(inHi), .in_lo_i(inLo), .busy_o(busy), .out_valid_o(outValid),
        .hi_o(hi), .lo_o(lo), .div_zero_o(divZero)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t modelOp(input logic [1:0] o, input logic s,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t        e;
        longint      p;
        logic [63:0] r;
        e.dz  = 1'b0;
        e.due = 0;
        if (o == 2'b11) begin
            if (b == 0) begin
                e.lo = '1; e.hi = a; e.dz = 1'b1;
            end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000; e.hi = '0;
            end else if (s) begin
                e.lo = $signed(a) / $signed(b);
                e.hi = $signed(a) % $signed(b);
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end else begin
            if (s) p = longint'($signed(a)) * longint'($signed(b));
            else   p = longint'({32'd0, a}) * longint'({32'd0, b});
            r = 64'(p);
            if (o == 2'b01)      r = {h, l} + r;
            else if (o == 2'b10) r = {h, l} - r;
            e.hi = r[63:32];
            e.lo = r[31:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && outValid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", 64'(1), 64'(0));
            end else begin
                mon = expQ.pop_front();
                checkOutput("hi", 64'(hi), 64'(mon.hi));
                checkOutput("lo", 64'(lo), 64'(mon.lo));
                checkOutput("div_zero", 64'(divZero), 64'(mon.dz));
                checkOutput("latency", 64'(edgeCnt), 64'(mon.due));
            end
        end
    end

    task automatic waitDrain();
        int guard = 0;
        @(negedge clk); #1;
        while (expQ.size() != 0 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
            expQ.delete();
        end
    endtask

    task automatic driveReq(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l);
        inValid = 1'b1; op = o; sign = s; srca = a; srcb = b; inHi = h; inLo = l;
    endtask

    task automatic scramble();
        srca = $urandom; srcb = $urandom; inHi = $urandom; inLo = $urandom;
        op = 2'($urandom); sign = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t e;
        waitDrain();
        e     = modelOp(o, s, a, b, h, l);
        e.due = edgeCnt + ((o == 2'b11) ? DLAT : LAT);
        expQ.push_back(e);
        lastHi = e.hi;
        lastLo = e.lo;
        driveReq(o, s, a, b, h, l);
        @(posedge clk); #1;
        inValid = 1'b0;
        scramble();
        @(negedge clk);
        checkOutput("busy_cycle1", 64'(busy), 64'(1));
    endtask

    initial begin
        exp_t e;
        int   base;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; op = '0; sign = 1'b0;
        srca = '0; srcb = '0; inHi = '0; inLo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_valid", 64'(outValid), 64'(0));
        checkOutput("rst_hi", 64'(hi), 64'(0));
        checkOutput("rst_lo", 64'(lo), 64'(0));
        checkOutput("rst_dz", 64'(divZero), 64'(0));
        rst = 1'b0;

        applyStimulus(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, '0, '0);
        applyStimulus(2'b01, 1'b0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 1'b0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, '0, '0);
        applyStimulus(2'b11, 1'b0, 32'h0000_1234, 32'd0, '0, '0);
        applyStimulus(2'b11, 1'b1, 32'hFFFF_1234, 32'd0, '0, '0);
        applyStimulus(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
        applyStimulus(2'b11, 1'b0, 32'hFFFF_FFFF, 32'd10, '0, '0);
        applyStimulus(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'($urandom), 1'($urandom), $urandom,
                          (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom),
                          $urandom, $urandom);
        end

        // in_valid held across busy: one accept per op, re-accepted in each out_valid cycle
        waitDrain();
        base  = edgeCnt;
        e     = modelOp(2'b00, 1'b0, 32'h0001_0001, 32'h0003_0003, '0, '0);
        for (int k = 1; k <= 3; k++) begin
            e.due = base + k * LAT;
            expQ.push_back(e);
        end
        lastHi = e.hi;
        lastLo = e.lo;
        driveReq(2'b00, 1'b0, 32'h0001_0001, 32'h0003_0003, '0, '0);
        @(posedge clk);
        repeat (2 * LAT) @(posedge clk);
        #1 inValid = 1'b0;

        // flush in cycle 5 of a divide, with a competing request in the same cycle
        waitDrain();
        driveReq(2'b11, 1'b1, 32'd100, 32'd7, '0, '0);
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_before_flush", 64'(busy), 64'(1));
        flush = 1'b1;
        driveReq(2'b00, 1'b0, 32'd5, 32'd6, '0, '0);
        @(negedge clk);
        flush = 1'b0;
        inValid = 1'b0;
        checkOutput("busy_after_flush", 64'(busy), 64'(0));
        checkOutput("valid_after_flush", 64'(outValid), 64'(0));
        checkOutput("hi_hold_flush", 64'(hi), 64'(lastHi));
        checkOutput("lo_hold_flush", 64'(lo), 64'(lastLo));
        repeat (DLAT + 5) @(negedge clk);
        checkOutput("hi_hold_late", 64'(hi), 64'(lastHi));

        // reset in the middle of a divide discards it and clears the outputs
        driveReq(2'b11, 1'b0, 32'd50, 32'd3, '0, '0);
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_hi", 64'(hi), 64'(0));
        checkOutput("midrst_lo", 64'(lo), 64'(0));
        repeat (DLAT + 4) @(negedge clk);
        checkOutput("midrst_lo_late", 64'(lo), 64'(0));

        applyStimulus(2'b00, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, '0, '0);
        waitDrain();
        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
